// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, display payload and hex glyph table for the 4-digit
// seven-segment scan driver.
package seg7_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NIB_W      = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  // One complete display configuration (captured by load)
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        zero_sup;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{data: 16'h0000, dp: 4'h0, blank: 4'hF, zero_sup: 1'b0};

  // Active-low {a,b,c,d,e,f,g}; b and d lowercase, A/C/E/F uppercase
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      default: g = 7'h38;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble + decimal point to active-low {a..g,h} pattern.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_c
);

  assign seg_c = {hex_glyph(nibble), ~dp};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with guard
// blanking, leading-zero suppression and frame-synchronous updates.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        zero_sup,
  output logic [3:0]  select,
  output logic [7:0]  number,
  output logic        frame_done,
  output logic        upd_pending
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  frame_end;
  logic                  in_guard;
  disp_cfg_t             in_cfg;
  disp_cfg_t             pend_cfg;
  disp_cfg_t             shadow;
  logic [NUM_DIGITS-1:0] zero_dig;
  logic [NUM_DIGITS-1:0] sup;
  logic                  run;
  logic [NIB_W-1:0]      cur_nib;
  logic [7:0]            seg_c;
  logic [3:0]            sel_nxt;
  logic [7:0]            num_nxt;

  assign tick      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign in_guard  = (GUARD_CYC != 0) && (32'(cnt) < GUARD_CYC);
  assign in_cfg    = '{data: data, dp: dp_in, blank: blank_in, zero_sup: zero_sup};

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending/shadow handshake: shadow only changes at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cfg    <= CFG_RESET;
      shadow      <= CFG_RESET;
      upd_pending <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        shadow <= in_cfg;
      end else if (upd_pending) begin
        shadow <= pend_cfg;
      end
      upd_pending <= 1'b0;
    end else if (load) begin
      pend_cfg    <= in_cfg;
      upd_pending <= 1'b1;
    end
  end

  // Leading-zero suppression, scanning from the top digit; digit0 always shown
  always_comb begin
    zero_dig = '0;
    sup      = '0;
    run      = shadow.zero_sup;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_dig[i] = (shadow.data[4*i +: 4] == 4'h0);
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run    = run & zero_dig[i];
      sup[i] = run;
    end
  end

  assign cur_nib = shadow.data[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .dp     (shadow.dp[idx]),
    .seg_c  (seg_c)
  );

  always_comb begin
    sel_nxt = SEL_OFF;
    num_nxt = SEG_OFF;
    if (!in_guard) begin
      sel_nxt = ~(4'b0001 << idx);
      if (shadow.blank[idx]) begin
        num_nxt = SEG_OFF;
      end else if (sup[idx]) begin
        num_nxt = {7'h7F, ~shadow.dp[idx]};
      end else begin
        num_nxt = seg_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select     <= SEL_OFF;
      number     <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      select     <= sel_nxt;
      number     <= num_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model queues
// the expected outputs per cycle and a monitor compares them against the DUT.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        zs;
  } cfg_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] num;
    logic       fd;
    logic       up;
  } exp_t;

  localparam cfg_t CFG_RST  = '{16'h0000, 4'h0, 4'hF, 1'b0};
  localparam cfg_t CFG_NONE = '{16'h0000, 4'h0, 4'h0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        zero_sup = 1'b0;
  logic [3:0]  select;
  logic [7:0]  number;
  logic        frame_done;
  logic        upd_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: position in scan (cycles since reset release), frame content
  int   p = 0;
  cfg_t shown = CFG_RST;
  cfg_t last = CFG_RST;
  bit   has_last = 1'b0;
  exp_t expq[$];

  string segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg7_scan_driver #(.REFRESH_DIV(DIV), .GUARD_CYC(GUARD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data        (data),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .zero_sup    (zero_sup),
    .select      (select),
    .number      (number),
    .frame_done  (frame_done),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Lit segments listed by letter; everything else dark (active-low)
  function automatic logic [7:0] glyph(input int n, input bit dp);
    logic [7:0] r = 8'hFF;
    string s = segs[n];
    for (int i = 0; i < s.len(); i++) begin
      int k = int'(s[i]) - int'("a");
      r[7-k] = 1'b0;
    end
    if (dp) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] digit_pattern(input cfg_t c, input int d);
    bit sup;
    if (c.blank[d]) return 8'hFF;
    sup = c.zs && (d != 0);
    for (int j = d; j < 4; j++) if (c.data[4*j +: 4] != 4'h0) sup = 1'b0;
    if (sup) return {7'h7F, ~c.dp[d]};
    return glyph(int'(c.data[4*d +: 4]), c.dp[d]);
  endfunction

  // Expected outputs after the coming clock edge; frame F shows the last load before its start
  task automatic push_expect(input logic ld, input cfg_t c);
    exp_t e;
    int   off;
    int   dig;
    if (!rst_n) begin
      e = '{4'hF, 8'hFF, 1'b0, 1'b0};
      p = 0;
      shown = CFG_RST;
      has_last = 1'b0;
    end else begin
      off = p % DIV;
      dig = (p / DIV) % 4;
      if (off < GUARD) begin
        e.sel = 4'hF;
        e.num = 8'hFF;
      end else begin
        e.sel = 4'hF;
        e.sel[dig] = 1'b0;
        e.num = digit_pattern(shown, dig);
      end
      e.fd = ((p % FRAME) == FRAME - 1);
      if (ld) begin
        last = c;
        has_last = 1'b1;
      end
      e.up = has_last && !e.fd;
      if (e.fd) begin
        if (has_last) shown = last;
        has_last = 1'b0;
      end
      p++;
    end
    expq.push_back(e);
  endtask

  task automatic cycle(input logic ld, input cfg_t c, input logic r);
    @(negedge clk);
    rst_n    = r;
    load     = ld;
    data     = c.data;
    dp_in    = c.dp;
    blank_in = c.blank;
    zero_sup = c.zs;
    if (!r) begin
      #1;
      check("async_rst_select", 32'(select), 32'hF);
      check("async_rst_number", 32'(number), 32'hFF);
      check("async_rst_pending", 32'(upd_pending), 32'h0);
    end
    push_expect(ld, c);
  endtask

  task automatic idle();
    cycle(1'b0, CFG_NONE, 1'b1);
  endtask

  // Monitor: outputs are presented every cycle, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("select", 32'(select), 32'(e.sel));
        check("number", 32'(number), 32'(e.num));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("upd_pending", 32'(upd_pending), 32'(e.up));
      end
    end
  end

  initial begin
    cfg_t c;
    logic ld;
    repeat (3) cycle(1'b0, CFG_NONE, 1'b0);
    repeat (70) idle();
    cycle(1'b1, '{16'h12AF, 4'h0, 4'h0, 1'b0}, 1'b1);
    repeat (80) idle();
    cycle(1'b1, '{16'h0070, 4'b1000, 4'h0, 1'b1}, 1'b1);
    repeat (70) idle();
    while ((p % FRAME) != 5) idle();
    cycle(1'b1, '{16'hAAAA, 4'h1, 4'h0, 1'b0}, 1'b1);
    repeat (10) idle();
    cycle(1'b1, '{16'hBBBB, 4'h2, 4'h0, 1'b0}, 1'b1);
    repeat (70) idle();
    while ((p % FRAME) != FRAME - 1) idle();
    cycle(1'b1, '{16'h0C0D, 4'h4, 4'h2, 1'b1}, 1'b1);
    repeat (70) idle();
    cycle(1'b1, '{16'h9876, 4'hF, 4'h0, 1'b0}, 1'b1);
    while ((p % DIV) != 4) idle();
    repeat (2) cycle(1'b0, CFG_NONE, 1'b0);
    repeat (70) idle();
    for (int i = 0; i < 900; i++) begin
      c.data  = 16'($urandom);
      c.dp    = 4'($urandom);
      c.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      c.zs    = 1'($urandom);
      if (($urandom_range(0, 3) == 0) && (c.zs)) c.data[15:8] = 8'h00;
      ld = ($urandom_range(0, 9) == 0) || (((p % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1));
      cycle(ld, c, 1'b1);
    end
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
